// File: rtl/pht_pkg.sv
// Shared definitions for the pattern-history-table counter engine.
//   PHT_CTR_W    : counter width the ctr_t type is built on
//   ctr_t        : one saturating counter
//   state_t      : sequencer state (INIT sweep, RUN arbitration)
//   sat_ctr_next : counter after one training event, clamped at 0 and all-ones
package pht_pkg;

    localparam int PHT_CTR_W = 2;

    typedef logic [PHT_CTR_W-1:0] ctr_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic ctr_t sat_ctr_next(ctr_t c, logic taken);
        ctr_t r;
        r = c;
        if (taken) begin
            if (c != '1) r = ctr_t'(c + 1'b1);
        end else begin
            if (c != '0) r = ctr_t'(c - 1'b1);
        end
        return r;
    endfunction

endpackage

// File: rtl/pht_ctr_engine.sv
// Front-end sequencer for a table of saturating counters kept in an external
// single-port RAM (one access per cycle, read data one cycle after address).
// After reset it sweeps every entry to INIT_VAL, then arbitrates lookups
// against read-modify-write training updates.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   lu_valid/lu_addr/lu_ready  lookup request; accepted when valid & ready
//   lu_rsp_valid/ctr/pred      lookup result, one cycle after accept (pulse)
//   upd_valid/addr/taken/ready training update; ready means its read issues now
//   init_done                  high exactly while the sequencer is in RUN
//   ram_addr/wr_data/wr_en     RAM command for this cycle
//   ram_rd_data                RAM data for the address of the previous cycle
//
// Handshake: a request transfers on a cycle where valid and ready are both
// high at the rising edge; ready never depends on ram_rd_data. Responses have
// no backpressure.
module pht_ctr_engine
    import pht_pkg::*;
#(
    parameter int LG_DEPTH   = 10,
    parameter int CTR_W      = 2,
    parameter int INIT_VAL   = 1,
    parameter int STARVE_LIM = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                lu_valid,
    input  logic [LG_DEPTH-1:0] lu_addr,
    output logic                lu_ready,
    output logic                lu_rsp_valid,
    output logic [CTR_W-1:0]    lu_rsp_ctr,
    output logic                lu_rsp_pred,
    input  logic                upd_valid,
    input  logic [LG_DEPTH-1:0] upd_addr,
    input  logic                upd_taken,
    output logic                upd_ready,
    output logic                init_done,
    output logic [LG_DEPTH-1:0] ram_addr,
    output logic [CTR_W-1:0]    ram_wr_data,
    output logic                ram_wr_en,
    input  logic [CTR_W-1:0]    ram_rd_data
);

    localparam int SW = $clog2(STARVE_LIM + 1);

    state_t              state_q, state_d;
    logic [LG_DEPTH-1:0] idx_q, idx_d;
    logic                wb_pend_q, wb_pend_d;
    logic [LG_DEPTH-1:0] wb_addr_q, wb_addr_d;
    logic                wb_taken_q, wb_taken_d;
    logic [SW-1:0]       starve_q, starve_d;
    logic                rsp_valid_q, rsp_valid_d;

    logic run;
    logic starved;
    logic lu_fire;
    logic upd_fire;

    assign run       = (state_q == RUN);
    assign starved   = (starve_q == SW'(STARVE_LIM));
    assign init_done = run;

    assign lu_ready  = run & ~wb_pend_q & ~(upd_valid & starved);
    assign upd_ready = run & ~wb_pend_q & (~lu_valid | starved);
    assign lu_fire   = lu_valid & lu_ready;
    assign upd_fire  = upd_valid & upd_ready;

    assign lu_rsp_valid = rsp_valid_q;
    assign lu_rsp_ctr   = ram_rd_data;
    assign lu_rsp_pred  = ram_rd_data[CTR_W-1];

    // RAM command. Writes are masked while reset is held so a writeback that
    // was in flight when reset arrived never reaches the table.
    always_comb begin
        ram_addr    = lu_addr;
        ram_wr_data = '0;
        ram_wr_en   = 1'b0;
        if (!run) begin
            ram_addr    = idx_q;
            ram_wr_data = CTR_W'(INIT_VAL);
            ram_wr_en   = ~reset;
        end else if (wb_pend_q) begin
            ram_addr    = wb_addr_q;
            ram_wr_data = CTR_W'(sat_ctr_next(ctr_t'(ram_rd_data), wb_taken_q));
            ram_wr_en   = ~reset;
        end else if (upd_fire) begin
            ram_addr = upd_addr;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wb_pend_d   = 1'b0;
        wb_addr_d   = wb_addr_q;
        wb_taken_d  = wb_taken_q;
        starve_d    = starve_q;
        rsp_valid_d = lu_fire;

        if (!run) begin
            idx_d = idx_q + 1'b1;
            if (idx_q == '1) state_d = RUN;
        end

        if (upd_fire) begin
            wb_pend_d  = 1'b1;
            wb_addr_d  = upd_addr;
            wb_taken_d = upd_taken;
        end

        // Counts lookups that won while an update was waiting.
        if (!upd_valid || upd_fire) begin
            starve_d = '0;
        end else if (lu_fire && !starved) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= INIT;
            idx_q       <= '0;
            wb_pend_q   <= 1'b0;
            wb_addr_q   <= '0;
            wb_taken_q  <= 1'b0;
            starve_q    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wb_pend_q   <= wb_pend_d;
            wb_addr_q   <= wb_addr_d;
            wb_taken_q  <= wb_taken_d;
            starve_q    <= starve_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

endmodule

// File: tb/tb_pht_ctr_engine.sv
// Bench for pht_ctr_engine with a 16-entry, 2-bit table and a 1-cycle RAM.
module tb_pht_ctr_engine;

    localparam int LGD   = 4;
    localparam int DEPTH = 16;
    localparam int CW    = 2;
    localparam int IV    = 1;
    localparam int LIM   = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           lu_valid = 1'b0;
    logic [LGD-1:0] lu_addr = '0;
    logic           lu_ready;
    logic           lu_rsp_valid;
    logic [CW-1:0]  lu_rsp_ctr;
    logic           lu_rsp_pred;
    logic           upd_valid = 1'b0;
    logic [LGD-1:0] upd_addr = '0;
    logic           upd_taken = 1'b0;
    logic           upd_ready;
    logic           init_done;
    logic [LGD-1:0] ram_addr;
    logic [CW-1:0]  ram_wr_data;
    logic           ram_wr_en;
    logic [CW-1:0]  ram_rd_data;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [CW-1:0] exp_q[$];
    int            ref_mem[DEPTH];

    logic [CW-1:0] mem[DEPTH];
    logic [CW-1:0] rd_q = '0;

    pht_ctr_engine #(
        .LG_DEPTH(LGD), .CTR_W(CW), .INIT_VAL(IV), .STARVE_LIM(LIM)
    ) dut (
        .clk(clk), .reset(reset),
        .lu_valid(lu_valid), .lu_addr(lu_addr), .lu_ready(lu_ready),
        .lu_rsp_valid(lu_rsp_valid), .lu_rsp_ctr(lu_rsp_ctr), .lu_rsp_pred(lu_rsp_pred),
        .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_taken(upd_taken),
        .upd_ready(upd_ready), .init_done(init_done),
        .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en),
        .ram_rd_data(ram_rd_data)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // single-port RAM, read data one cycle after address
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_addr] <= ram_wr_data;
        rd_q <= mem[ram_addr];
    end
    assign ram_rd_data = rd_q;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // scoreboard monitor: reference model updated on accepted requests,
    // responses popped and compared whenever the DUT presents one
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = IV;
        end else begin
            if (lu_rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    logic [CW-1:0] e;
                    e = exp_q.pop_front();
                    check("rsp_ctr", lu_rsp_ctr, e);
                    check("rsp_pred", lu_rsp_pred, e[CW-1]);
                end
            end
            if (lu_valid && lu_ready) exp_q.push_back(CW'(ref_mem[lu_addr]));
            if (upd_valid && upd_ready) begin
                if (upd_taken) ref_mem[upd_addr] = (ref_mem[upd_addr] == 3) ? 3 : ref_mem[upd_addr] + 1;
                else           ref_mem[upd_addr] = (ref_mem[upd_addr] == 0) ? 0 : ref_mem[upd_addr] - 1;
            end
        end
    end

    // driver tasks
    task automatic do_lookup(input logic [LGD-1:0] a);
        int n = 0;
        lu_valid = 1'b1;
        lu_addr  = a;
        @(negedge clk);
        while (!lu_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!lu_ready) check("lu_timeout", 0, 1);
        @(posedge clk);
        #1 lu_valid = 1'b0;
    endtask

    task automatic do_update(input logic [LGD-1:0] a, input logic t);
        int n = 0;
        upd_valid = 1'b1;
        upd_addr  = a;
        upd_taken = t;
        @(negedge clk);
        while (!upd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!upd_ready) check("upd_timeout", 0, 1);
        @(posedge clk);
        #1 upd_valid = 1'b0;
    endtask

    // called just after reset release: expect the 16-cycle sweep then init_done
    task automatic sweep_check();
        int bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            if (!(ram_wr_en === 1'b1 && ram_addr === LGD'(i) && ram_wr_data === CW'(IV) &&
                  init_done === 1'b0 && lu_ready === 1'b0 && upd_ready === 1'b0)) begin
                if (bad == 0)
                    $display("FAIL sweep_cycle_%0d: we=%0b addr=%0d data=%0d done=%0b lr=%0b ur=%0b",
                             i, ram_wr_en, ram_addr, ram_wr_data, init_done, lu_ready, upd_ready);
                bad++;
            end
        end
        check("sweep_bad_cycles", bad, 0);
        @(negedge clk);
        check("init_done_rise", init_done, 1);
        check("sweep_stops", ram_wr_en, 0);
        @(posedge clk);
        #1;
    endtask

    logic [6:0] st_lu;
    logic [6:0] st_up;

    initial begin
        // reset state
        @(negedge clk);
        check("rst_init_done", init_done, 0);
        check("rst_lu_ready", lu_ready, 0);
        check("rst_upd_ready", upd_ready, 0);
        check("rst_rsp_valid", lu_rsp_valid, 0);
        check("rst_wr_en", ram_wr_en, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        sweep_check();

        // single lookup latency and pulse
        do_lookup(5);
        @(negedge clk);
        check("rsp_latency", lu_rsp_valid, 1);
        check("rsp_init_val", lu_rsp_ctr, 1);
        @(negedge clk);
        check("rsp_pulse", lu_rsp_valid, 0);
        @(posedge clk);
        #1;

        // saturation up then down
        repeat (3) do_update(3, 1'b1);
        do_lookup(3);
        repeat (5) do_update(3, 1'b0);
        do_lookup(3);
        repeat (3) @(posedge clk);
        #1;

        // starvation: 4 lookups win, then the update, then its writeback
        st_lu = 7'b1001111;
        st_up = 7'b0010000;
        lu_valid = 1'b1; lu_addr = 5;
        upd_valid = 1'b1; upd_addr = 9; upd_taken = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check($sformatf("starve_lu_%0d", k), lu_ready, st_lu[k]);
            check($sformatf("starve_upd_%0d", k), upd_ready, st_up[k]);
            if (k == 5) check("starve_wb_we", ram_wr_en, 1);
            @(posedge clk);
            #1;
        end
        lu_valid = 1'b0;
        upd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // update-then-lookup hazard on addr 7
        upd_valid = 1'b1; upd_addr = 7; upd_taken = 1'b1;
        @(negedge clk);
        check("haz_upd_ready", upd_ready, 1);
        @(posedge clk);
        #1 upd_valid = 1'b0; lu_valid = 1'b1; lu_addr = 7;
        @(negedge clk);
        check("haz_lu_blocked", lu_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("haz_lu_accept", lu_ready, 1);
        @(posedge clk);
        #1 lu_valid = 1'b0;
        @(negedge clk);
        check("haz_rsp_valid", lu_rsp_valid, 1);
        check("haz_ctr", lu_rsp_ctr, 2);
        @(posedge clk);
        #1;

        // reset during a writeback cycle
        do_update(4, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("wb_killed", ram_wr_en, 0);
        check("rst_mid_rsp", lu_rsp_valid, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        sweep_check();
        do_lookup(4);
        @(negedge clk);
        check("after_rst_ctr", lu_rsp_ctr, 1);
        @(posedge clk);
        #1;

        // randomized traffic against the reference model
        for (int c = 0; c < 600; c++) begin
            lu_valid  = ($urandom_range(0, 99) < 60);
            lu_addr   = LGD'($urandom_range(0, DEPTH - 1));
            upd_valid = ($urandom_range(0, 99) < 45);
            upd_addr  = LGD'($urandom_range(0, 7));
            upd_taken = ($urandom_range(0, 1) == 1);
            @(posedge clk);
            #1;
        end
        lu_valid = 1'b0;
        upd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
